// File: rtl/dsp_post_adder_acc.sv
// ============================================================================
// Module   : dsp_post_adder_acc
// Brief    : Post-adder/accumulator with OPMODE-selected X/Z operands, P register
//            with internal accumulate feedback, and PCOUT cascade.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_post_adder_acc #(
  parameter int WIDTHM      = 36,
  parameter int WIDTHP      = 48,
  parameter int OPMODEREG   = 1,
  parameter int CARRYINREG  = 1,
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ceopmode,
  input  logic              cecarryin,
  input  logic              cep,
  input  logic [7:0]        opmode,
  input  logic              carryin,
  input  logic [WIDTHM-1:0] m,
  input  logic [WIDTHP-1:0] dab,
  input  logic [WIDTHP-1:0] c,
  input  logic [WIDTHP-1:0] pcin,
  output logic [WIDTHP-1:0] p,
  output logic [WIDTHP-1:0] pcout,
  output logic              carryout,
  output logic              carryoutf
);

  logic [7:0]        opmode_r;
  logic              carryin_r;
  logic [WIDTHP-1:0] p_reg;
  logic              carry_r;

  logic [7:0]        op_e;
  logic              cin_e;
  logic [WIDTHP-1:0] m_ext;
  logic [WIDTHP-1:0] x_mux;
  logic [WIDTHP-1:0] z_mux;
  logic [WIDTHP:0]   sum;
  logic [WIDTHP-1:0] res;
  logic              co;
  logic              unused_opmode_bits;

  assign op_e  = (OPMODEREG != 0) ? opmode_r : opmode;
  assign cin_e = (CARRYINREG != 0) ? carryin_r : carryin;
  assign m_ext = {{(WIDTHP-WIDTHM){m[WIDTHM-1]}}, m};

  // Bits [6:4] steer the pre-adder upstream and have no role here.
  assign unused_opmode_bits = ^op_e[6:4];

  // Feedback always taps the P register so PREG=0 cannot form a loop.
  always_comb begin
    x_mux = '0;
    case (op_e[1:0])
      2'd0:    x_mux = '0;
      2'd1:    x_mux = m_ext;
      2'd2:    x_mux = p_reg;
      default: x_mux = dab;
    endcase
  end

  always_comb begin
    z_mux = '0;
    case (op_e[3:2])
      2'd0:    z_mux = '0;
      2'd1:    z_mux = pcin;
      2'd2:    z_mux = p_reg;
      default: z_mux = c;
    endcase
  end

  // The carry-in joins X before subtraction, so bit WIDTHP is the borrow.
  always_comb begin
    sum = '0;
    if (op_e[7])
      sum = {1'b0, z_mux} - ({1'b0, x_mux} + {{WIDTHP{1'b0}}, cin_e});
    else
      sum = {1'b0, z_mux} + {1'b0, x_mux} + {{WIDTHP{1'b0}}, cin_e};
  end

  assign res = sum[WIDTHP-1:0];
  assign co  = sum[WIDTHP];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      opmode_r <= '0;
    else if (ceopmode)
      opmode_r <= opmode;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      carryin_r <= 1'b0;
    else if (cecarryin)
      carryin_r <= carryin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_reg   <= '0;
      carry_r <= 1'b0;
    end else if (cep) begin
      p_reg   <= res;
      carry_r <= co;
    end
  end

  generate
    if (PREG != 0) begin : g_p_registered
      assign p = p_reg;
    end else begin : g_p_comb
      assign p = res;
    end

    if (CARRYOUTREG != 0) begin : g_co_registered
      assign carryout = carry_r;
    end else begin : g_co_comb
      assign carryout = co;
    end
  endgenerate

  assign pcout     = p;
  assign carryoutf = carryout;

endmodule

`default_nettype wire

// File: tb/tb_dsp_post_adder_acc.sv
// ============================================================================
// Module   : tb_dsp_post_adder_acc
// Brief    : Directed vector bench for the registered and bypass configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsp_post_adder_acc;

  localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

  typedef struct {
    logic [7:0]  op;
    logic        cin;
    logic [35:0] m;
    logic [47:0] dab;
    logic [47:0] c;
    logic [47:0] pcin;
    logic        cep;
    logic        ceop;
    logic [47:0] exp_p;
    logic        exp_co;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ceopmode = 1'b1, cecarryin = 1'b1, cep = 1'b1;
  logic [7:0]  opmode = 8'h00;
  logic        carryin = 1'b0;
  logic [35:0] m = '0;
  logic [47:0] dab = '0, c = '0, pcin = '0;
  logic [47:0] p, pcout;
  logic        carryout, carryoutf;

  logic        b_cep = 1'b0;
  logic [7:0]  b_opmode = 8'h00;
  logic        b_carryin = 1'b0;
  logic [35:0] b_m = '0;
  logic [47:0] b_dab = '0, b_c = '0, b_pcin = '0;
  logic [47:0] b_p, b_pcout;
  logic        b_carryout, b_carryoutf;

  always #5 clk = ~clk;

  dsp_post_adder_acc dut (
    .clk(clk), .rst(rst), .ceopmode(ceopmode), .cecarryin(cecarryin), .cep(cep),
    .opmode(opmode), .carryin(carryin), .m(m), .dab(dab), .c(c), .pcin(pcin),
    .p(p), .pcout(pcout), .carryout(carryout), .carryoutf(carryoutf)
  );

  dsp_post_adder_acc #(
    .OPMODEREG(0), .CARRYINREG(0), .PREG(0), .CARRYOUTREG(0)
  ) dut_byp (
    .clk(clk), .rst(rst), .ceopmode(1'b1), .cecarryin(1'b1), .cep(b_cep),
    .opmode(b_opmode), .carryin(b_carryin), .m(b_m), .dab(b_dab), .c(b_c), .pcin(b_pcin),
    .p(b_p), .pcout(b_pcout), .carryout(b_carryout), .carryoutf(b_carryoutf)
  );

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic [47:0] ep, input logic eco);
    check({tag, " p"}, p, ep);
    check({tag, " pcout"}, pcout, ep);
    check({tag, " carryout"}, {47'd0, carryout}, {47'd0, eco});
    check({tag, " carryoutf"}, {47'd0, carryoutf}, {47'd0, eco});
  endtask

  task automatic check_byp(input string tag, input logic [47:0] ep, input logic eco);
    check({tag, " p"}, b_p, ep);
    check({tag, " pcout"}, b_pcout, ep);
    check({tag, " carryout"}, {47'd0, b_carryout}, {47'd0, eco});
    check({tag, " carryoutf"}, {47'd0, b_carryoutf}, {47'd0, eco});
  endtask

  task automatic add(input logic [7:0] op, input logic cin, input logic [35:0] mv,
                     input logic [47:0] dv, input logic [47:0] cv, input logic [47:0] pv,
                     input logic cepv, input logic ceopv, input logic [47:0] ep, input logic eco);
    vec_t v;
    v.op = op; v.cin = cin; v.m = mv; v.dab = dv; v.c = cv; v.pcin = pv;
    v.cep = cepv; v.ceop = ceopv; v.exp_p = ep; v.exp_co = eco;
    vecs.push_back(v);
  endtask

  initial begin
    // Expected values account for the one-cycle opmode/carry-in register lag.
    add(8'h09, 0, 36'd3, 0, 0, 0, 1, 1, 48'd0, 0);
    add(8'h09, 0, 36'd3, 0, 0, 0, 1, 1, 48'd3, 0);
    add(8'h09, 0, 36'd3, 0, 0, 0, 1, 1, 48'd6, 0);
    add(8'h09, 0, 36'd3, 0, 0, 0, 1, 1, 48'd9, 0);
    add(8'h09, 0, 36'd3, 0, 0, 0, 1, 1, 48'd12, 0);
    add(8'h09, 0, 36'd3, 0, 0, 0, 0, 1, 48'd12, 0);
    add(8'h09, 0, 36'd3, 0, 0, 0, 0, 1, 48'd12, 0);
    add(8'h09, 0, 36'd3, 0, 0, 0, 1, 1, 48'd15, 0);
    add(8'h8D, 0, 36'd3, 0, 5, 0, 1, 0, 48'd18, 0);
    add(8'h8D, 0, 36'd3, 0, 5, 0, 1, 0, 48'd21, 0);
    add(8'h8D, 0, 36'd7, 0, 5, 0, 1, 1, 48'd28, 0);
    add(8'h8D, 0, 36'd7, 0, 5, 0, 1, 1, 48'hFFFF_FFFF_FFFE, 1);
    add(8'h8D, 0, 36'd7, 0, 10, 0, 1, 1, 48'd3, 0);
    add(8'h0C, 0, 36'd7, 0, 10, 0, 1, 1, 48'd3, 0);
    add(8'h0E, 0, 36'd0, 0, ONES, 0, 1, 1, ONES, 0);
    add(8'h0E, 0, 36'd0, 0, 1, 0, 1, 1, 48'd0, 1);
    add(8'h0E, 1, 36'd0, 0, 1, 0, 1, 1, 48'd1, 0);
    add(8'h0E, 0, 36'd0, 0, 1, 0, 1, 1, 48'd3, 0);
    add(8'h0A, 0, 36'd0, 0, 1, 0, 1, 1, 48'd4, 0);
    add(8'h0A, 0, 36'd0, 0, 1, 0, 1, 1, 48'd8, 0);
    add(8'h8A, 1, 36'd0, 0, 1, 0, 1, 1, 48'd16, 0);
    add(8'h8A, 1, 36'd0, 0, 1, 0, 1, 1, ONES, 1);
    add(8'h04, 0, 36'd0, 0, 0, 123, 1, 1, ONES, 1);
    add(8'h04, 0, 36'd0, 0, 0, 123, 1, 1, 48'd123, 0);
    add(8'h07, 0, 36'd0, 1000, 0, 123, 1, 1, 48'd123, 0);
    add(8'h07, 0, 36'd0, 1000, 0, 123, 1, 1, 48'd1123, 0);
    add(8'h05, 0, 36'hF_FFFF_FFFF, 1000, 0, 10, 1, 1, 48'd1010, 0);
    add(8'h05, 0, 36'hF_FFFF_FFFF, 1000, 0, 10, 1, 1, 48'd9, 1);
    add(8'h09, 0, 36'd3, 0, 0, 10, 1, 1, 48'd13, 0);
    add(8'h09, 0, 36'd3, 0, 0, 10, 1, 1, 48'd16, 0);

    // Reset with enables high and a non-zero opmode: reset must dominate.
    opmode = 8'h09; m = 36'd3; carryin = 1'b1;
    #1 check_main("reset", 48'd0, 0);
    @(posedge clk); #1 check_main("reset_edge", 48'd0, 0);
    @(negedge clk); rst = 1'b0; carryin = 1'b0;
    #1 check_main("post_release", 48'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      opmode = vecs[i].op; carryin = vecs[i].cin; m = vecs[i].m;
      dab = vecs[i].dab; c = vecs[i].c; pcin = vecs[i].pcin;
      cep = vecs[i].cep; ceopmode = vecs[i].ceop;
      @(posedge clk); #1;
      check_main($sformatf("vec%0d", i), vecs[i].exp_p, vecs[i].exp_co);
    end

    // Asynchronous reset between edges while accumulating.
    #2 rst = 1'b1;
    #1 check_main("async_rst", 48'd0, 0);
    @(posedge clk); #1 check_main("async_rst_edge", 48'd0, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1 check_main("resume0", 48'd0, 0);
    @(posedge clk); #1 check_main("resume1", 48'd3, 0);
    @(posedge clk); #1 check_main("resume2", 48'd6, 0);

    // Bypass configuration: combinational result in the same cycle.
    b_opmode = 8'h0F; b_dab = 48'd100; b_c = 48'd20; b_carryin = 1'b1;
    #1 check_byp("byp_add", 48'd121, 0);
    b_opmode = 8'h8F;
    #1 check_byp("byp_sub", 48'hFFFF_FFFF_FFAF, 1);
    b_opmode = 8'h0F; b_cep = 1'b1;
    @(posedge clk); #1 b_cep = 1'b0; b_opmode = 8'h0E; b_carryin = 1'b0;
    #1 check_byp("byp_feedback", 48'd141, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dsp_post_adder_acc.md
Name: dsp_post_adder_acc

Overview:
Post-adder/accumulator stage of the DSP48A1 slice model. It sits directly downstream of the M-register stage. It selects X and Z operands under OPMODE control, then adds or subtracts them with carry-in and registers the 48-bit result into the P register, with carry-out. P feeds back internally for multiply-accumulate and drives the PCOUT cascade to the next slice.

Parameters:
WIDTHM, 36, width of multiplier product input m (sign-extended to WIDTHP)
WIDTHP, 48, width of operands, P, PCIN, PCOUT, C, D:A:B
OPMODEREG, 1, 1 = opmode passes through an internal register (CE ceopmode); 0 = used directly
CARRYINREG, 1, 1 = carryin passes through an internal register (CE cecarryin); 0 = used directly
PREG, 1, 1 = p/pcout driven from the P register; 0 = driven from the combinational adder result
CARRYOUTREG, 1, 1 = carryout/carryoutf driven from the carry register; 0 = combinational

Ports:
clk  input  1  clock, all registers rising-edge
rst  input  1  asynchronous, active-high reset of every internal register
ceopmode  input  1  clock enable, opmode register
cecarryin  input  1  clock enable, carry-in register
cep  input  1  clock enable, P register and carry-out register
opmode  input  8  [1:0] X select, [3:2] Z select, [7] 1 = subtract; [6:4] ignored here (consumed upstream)
carryin  input  1  post-adder carry-in
m  input  WIDTHM  product from M stage, two's complement
dab  input  WIDTHP  concatenation {D[11:0], A[17:0], B[17:0]}, already formed upstream
c  input  WIDTHP  C operand
pcin  input  WIDTHP  cascade input from the previous slice
p  output  WIDTHP  result
pcout  output  WIDTHP  copy of p for cascade
carryout  output  1  post-adder carry/borrow out
carryoutf  output  1  copy of carryout (fabric)

Behaviour:
- Effective control: op_e = OPMODEREG ? opmode_r : opmode; cin_e = CARRYINREG ? carryin_r : carryin.
- X mux (op_e[1:0]): 0 → zero; 1 → m sign-extended to WIDTHP; 2 → P register; 3 → dab.
- Z mux (op_e[3:2]): 0 → zero; 1 → pcin; 2 → P register; 3 → c.
- Accumulator feedback always uses the internal P register, including when PREG=0. No combinational loop is permitted.
- Add (op_e[7]=0): {co, res} = {1'b0,Z} + {1'b0,X} + cin_e, computed at WIDTHP+1 bits.
- Subtract (op_e[7]=1): {co, res} = {1'b0,Z} − ({1'b0,X} + cin_e), computed at WIDTHP+1 bits. co is bit WIDTHP (1 = borrow).
- Result wraps modulo 2^WIDTHP. There is no saturation.
- Register updates on rising clk when not in reset:
  - opmode_r ← opmode if ceopmode
  - carryin_r ← carryin if cecarryin
  - P ← res if cep
  - carry_r ← co if cep
  - Any register whose CE is low holds its value.
- Registers are updated every cycle regardless of the *REG parameters. The parameters only select the output/consumer path.
- Latency with all *REG=1: opmode/carryin presented at edge k reach the adder after edge k. The result is visible on p after edge k+1. Data inputs m/dab/c/pcin are sampled combinationally, so their timing is the upstream stage's responsibility.
- Output mapping:
  - p = PREG ? P : res; pcout = p.
  - carryout = CARRYOUTREG ? carry_r : co; carryoutf = carryout.
- Reset: asserting rst immediately clears opmode_r, carryin_r, P and carry_r to 0. With all *REG=1, p, pcout, carryout and carryoutf read 0 during reset and on the first cycle after release.
- Reset mid-accumulation discards the running sum. The next accumulate starts from P=0.
- Simultaneous rst and CE: rst wins.
- When both X and Z select P, the result is 2·P (+cin), or cin-adjusted zero for subtract.

Test Plan:
1. MAC: all REG=1, opmode=8'h09 (X=M, Z=P), m=3, carryin=0, cep=1 for 4 cycles after reset → p steps 3, 6, 9, 12; carryout=0.
2. Subtract with borrow: opmode=8'h8D (Z=C, X=M, sub), c=5, m=7, carryin=0 → p=48'hFFFF_FFFF_FFFE, carryout=1. With c=10 → p=3, carryout=0.
3. Wrap-around: opmode=8'h0E (Z=C, X=P) seeded from P=48'hFFFF_FFFF_FFFF, c=1 → p=0, carryout=1.
4. CE hold: mid-MAC drop cep for 2 cycles → p and carryout frozen. Drop ceopmode while changing opmode → old opmode still applied.
5. Async reset mid-accumulate: assert rst between clock edges while p=12 → p=0 and carryout=0 before the next edge. Resume → p restarts at 3.
6. Bypass mode: PREG=0, CARRYOUTREG=0, OPMODEREG=0, opmode=8'h0F (Z=C, X=DAB), dab=100, c=20, carryin=1 → p=121 combinationally in the same cycle; pcout=p.
